relay_arbiter: RTL and testbench

Single-owner controller for the pump relay. Selects one of three relay requesters (manual, automatic fill, remote) by `mode` and enforces a minimum relay off-time. Applies a maximum on-time watchdog and an ultrasonic-sample staleness guard, and reports the duration of the last pump session in milliseconds. Sits between the per-mode relay generators and the physical relay driver pin.

---
 rtl/relay_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_relay_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/relay_arbiter.sv
// Single-owner pump relay controller: mode-selected request, enforced off-time, session timing.
// Define RELAY_WATCHDOG_EN to enable the max-on watchdog and the ultrasonic staleness guard.
`timescale 1ns / 1ps

module relay_arbiter #(
    parameter int unsigned CLK_HZ      = 1_000_000,
    parameter int unsigned MIN_OFF_CYC = 200_000,
    parameter int unsigned MAX_ON_CYC  = 60_000_000,
    parameter int unsigned STALE_CYC   = 500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mode,
    input  logic        req_manual,
    input  logic        req_auto,
    input  logic        req_remote,
    input  logic        dist_valid,
    input  logic        fault_clr,
    output logic        relay_out,
    output logic [1:0]  active_src,
    output logic [1:0]  state,
    output logic        fault,
    output logic [15:0] last_on_ms
);

    localparam int unsigned MsDiv  = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int unsigned MsDivW = (MsDiv > 1) ? $clog2(MsDiv) : 1;
    localparam int unsigned CoolW  = (MIN_OFF_CYC > 1) ? $clog2(MIN_OFF_CYC) : 1;

    localparam logic [1:0] ModeManual = 2'b00;
    localparam logic [1:0] ModeAuto   = 2'b01;
    localparam logic [1:0] ModeRemote = 2'b10;

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StOn       = 2'b01,
        StCooldown = 2'b10,
        StFault    = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          active_src_q, active_src_d;
    logic [15:0]         last_on_ms_q, last_on_ms_d;
    logic [15:0]         ms_cnt_q, ms_cnt_d;
    logic [MsDivW-1:0]   ms_div_q, ms_div_d;
    logic [CoolW-1:0]    cool_cnt_q, cool_cnt_d;
    logic                relay_q;

    logic sel_req;
    logic auto_blocked;
    logic watchdog_trip;
    logic stale_trip;

    always_comb begin
        sel_req = 1'b0;
        case (mode)
            ModeManual: sel_req = req_manual;
            ModeAuto:   sel_req = req_auto;
            ModeRemote: sel_req = req_remote;
            default:    sel_req = 1'b0;
        endcase
    end

`ifdef RELAY_WATCHDOG_EN
    localparam int unsigned StaleW = $clog2(STALE_CYC + 1);
    localparam int unsigned OnW    = (MAX_ON_CYC > 1) ? $clog2(MAX_ON_CYC) : 1;

    logic [StaleW-1:0] stale_cnt_q, stale_cnt_d;
    logic [OnW-1:0]    on_cnt_q, on_cnt_d;
    logic              stale;
    logic              fault_q;

    assign stale         = (stale_cnt_q == StaleW'(STALE_CYC));
    assign auto_blocked  = (mode == ModeAuto) && stale;
    assign watchdog_trip = (on_cnt_q == OnW'(MAX_ON_CYC - 1));
    assign stale_trip    = (active_src_q == ModeAuto) && stale;

    // A fresh sample always wins over the counter reaching its limit.
    always_comb begin
        stale_cnt_d = stale_cnt_q;
        if (dist_valid) begin
            stale_cnt_d = '0;
        end else if (!stale) begin
            stale_cnt_d = stale_cnt_q + 1'b1;
        end
    end

    // Held at zero while idle so every session starts counting from zero.
    always_comb begin
        on_cnt_d = on_cnt_q;
        if (state_q == StIdle) begin
            on_cnt_d = '0;
        end else if (state_q == StOn) begin
            on_cnt_d = on_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stale_cnt_q <= '0;
            on_cnt_q    <= '0;
            fault_q     <= 1'b0;
        end else begin
            stale_cnt_q <= stale_cnt_d;
            on_cnt_q    <= on_cnt_d;
            fault_q     <= (state_d == StFault);
        end
    end

    assign fault = fault_q;
`else
    logic unused_wd;

    assign auto_blocked  = 1'b0;
    assign watchdog_trip = 1'b0;
    assign stale_trip    = 1'b0;
    assign fault         = 1'b0;
    assign unused_wd     = ^{dist_valid, MAX_ON_CYC, STALE_CYC};
`endif

    always_comb begin
        state_d      = state_q;
        active_src_d = active_src_q;
        last_on_ms_d = last_on_ms_q;
        ms_cnt_d     = ms_cnt_q;
        ms_div_d     = ms_div_q;
        cool_cnt_d   = cool_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (sel_req && !auto_blocked) begin
                    state_d      = StOn;
                    active_src_d = mode;
                    ms_cnt_d     = '0;
                    ms_div_d     = '0;
                end
            end
            StOn: begin
                if (ms_div_q == MsDivW'(MsDiv - 1)) begin
                    ms_div_d = '0;
                    if (ms_cnt_q != 16'hFFFF) begin
                        ms_cnt_d = ms_cnt_q + 16'd1;
                    end
                end else begin
                    ms_div_d = ms_div_q + 1'b1;
                end

                if (watchdog_trip || stale_trip) begin
                    state_d      = StFault;
                    last_on_ms_d = ms_cnt_q;
                end else if (!sel_req || (mode != active_src_q)) begin
                    state_d      = StCooldown;
                    cool_cnt_d   = '0;
                    last_on_ms_d = ms_cnt_q;
                end
            end
            StCooldown: begin
                if (cool_cnt_q == CoolW'(MIN_OFF_CYC - 1)) begin
                    state_d = StIdle;
                end else begin
                    cool_cnt_d = cool_cnt_q + 1'b1;
                end
            end
            StFault: begin
                // The requester must let go before an acknowledge is honoured.
                if (fault_clr && !sel_req) begin
                    state_d    = StCooldown;
                    cool_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            active_src_q <= 2'b00;
            last_on_ms_q <= '0;
            ms_cnt_q     <= '0;
            ms_div_q     <= '0;
            cool_cnt_q   <= '0;
            relay_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_src_q <= active_src_d;
            last_on_ms_q <= last_on_ms_d;
            ms_cnt_q     <= ms_cnt_d;
            ms_div_q     <= ms_div_d;
            cool_cnt_q   <= cool_cnt_d;
            relay_q      <= (state_d == StOn);
        end
    end

    assign relay_out  = relay_q;
    assign state      = state_q;
    assign active_src = active_src_q;
    assign last_on_ms = last_on_ms_q;

endmodule

// File: tb/tb_relay_arbiter.sv
// Randomized + directed bench for relay_arbiter against a cycle-count reference model.
// Follows RELAY_WATCHDOG_EN the same way the design does.
`timescale 1ns / 1ps

module tb_relay_arbiter;

    localparam int CLK_HZ  = 4000;
    localparam int MIN_OFF = 10;
    localparam int MAX_ON  = 50;
    localparam int STALE   = 20;
    localparam int MS_DIV  = CLK_HZ / 1000;
`ifdef RELAY_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode;
    logic        req_manual, req_auto, req_remote;
    logic        dist_valid, fault_clr;
    logic        relay_out;
    logic [1:0]  active_src;
    logic [1:0]  state;
    logic        fault;
    logic [15:0] last_on_ms;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    relay_arbiter #(
        .CLK_HZ     (CLK_HZ),
        .MIN_OFF_CYC(MIN_OFF),
        .MAX_ON_CYC (MAX_ON),
        .STALE_CYC  (STALE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .req_manual(req_manual),
        .req_auto  (req_auto),
        .req_remote(req_remote),
        .dist_valid(dist_valid),
        .fault_clr (fault_clr),
        .relay_out (relay_out),
        .active_src(active_src),
        .state     (state),
        .fault     (fault),
        .last_on_ms(last_on_ms)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: phase 0 idle, 1 on, 2 cooldown, 3 fault (matches the state output codes).
    int m_state = 0, m_on_len = 0, m_cool = 0, m_since = 0, m_src = 0, m_last = 0;

    function automatic int ms_of(input int on_len);
        int v;
        v = (on_len - 1) / MS_DIV;
        return (v > 65535) ? 65535 : v;
    endfunction

    always @(posedge clk) begin : model
        int st, on_len, cool, since, src, last;
        bit sel, stale;
        st = m_state; on_len = m_on_len; cool = m_cool;
        since = m_since; src = m_src; last = m_last;
        case (mode)
            2'd0:    sel = req_manual;
            2'd1:    sel = req_auto;
            2'd2:    sel = req_remote;
            default: sel = 1'b0;
        endcase
        stale = WD && (since >= STALE);
        if (!rst_n) begin
            st = 0; on_len = 0; cool = 0; since = 0; src = 0; last = 0;
        end else begin
            case (st)
                0: if (sel && !(mode == 2'd1 && stale)) begin
                    st = 1; src = int'(mode); on_len = 0;
                end
                1: begin
                    on_len++;
                    if (WD && (on_len == MAX_ON || (src == 1 && stale))) begin
                        st = 3; last = ms_of(on_len);
                    end else if (!sel || int'(mode) != src) begin
                        st = 2; cool = MIN_OFF; last = ms_of(on_len);
                    end
                end
                2: begin
                    cool--;
                    if (cool == 0) st = 0;
                end
                default: if (fault_clr && !sel) begin
                    st = 2; cool = MIN_OFF;
                end
            endcase
            since = dist_valid ? 0 : ((since < 1000000) ? since + 1 : since);
        end
        m_state <= st; m_on_len <= on_len; m_cool <= cool;
        m_since <= since; m_src <= src; m_last <= last;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("relay_out", 32'(relay_out), 32'(m_state == 1));
            check("state", 32'(state), 32'(m_state));
            check("fault", 32'(fault), 32'(m_state == 3));
            check("active_src", 32'(active_src), 32'(m_src));
            check("last_on_ms", 32'(last_on_ms), 32'(m_last));
        end
    end

    int n_on, k;

    initial begin
        rst_n = 1'b0; mode = 2'd0;
        req_manual = 1'b0; req_auto = 1'b0; req_remote = 1'b0;
        dist_valid = 1'b0; fault_clr = 1'b0;
        tick(2);
        rst_n = 1'b1;
        check("rst_relay", 32'(relay_out), 0);
        check("rst_state", 32'(state), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_src", 32'(active_src), 0);
        check("rst_last", 32'(last_on_ms), 0);
        chk_en = 1'b1;

        // Manual session of 30 on-cycles.
        mode = 2'd0; req_manual = 1'b1;
        n_on = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (relay_out) n_on++;
        end
        req_manual = 1'b0;
        check("man_on_cycles", n_on, 30);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (state == 2'd2 && !relay_out) k++;
        end
        check("man_cool_cycles", k, MIN_OFF);
        tick(1);
        check("man_idle", 32'(state), 0);
        check("man_last_ms", 32'(last_on_ms), 7);

        // Watchdog with a held remote request.
        mode = 2'd2; req_remote = 1'b1;
`ifdef RELAY_WATCHDOG_EN
        n_on = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (relay_out) n_on++;
            else if (n_on > 0) break;
        end
        check("wd_on_cycles", n_on, MAX_ON);
        check("wd_fault", 32'(fault), 1);
        fault_clr = 1'b1; tick(1); fault_clr = 1'b0;
        check("wd_clr_ignored", 32'(state), 3);
        req_remote = 1'b0; tick(2);
        fault_clr = 1'b1; tick(1); fault_clr = 1'b0;
        check("wd_clr_cool", 32'(state), 2);
        tick(9);
        check("wd_cool_hold", 32'(state), 2);
        tick(1);
        check("wd_idle", 32'(state), 0);
`else
        tick(100);
        check("nowd_still_on", 32'(relay_out), 1);
        check("nowd_no_fault", 32'(fault), 0);
        req_remote = 1'b0; tick(12);
`endif

        // Stale sensor guard on auto mode.
        mode = 2'd1;
`ifdef RELAY_WATCHDOG_EN
        dist_valid = 1'b1; tick(1);
        dist_valid = 1'b0; req_auto = 1'b1; tick(1);
        check("stale_on", 32'(relay_out), 1);
        tick(13);
        dist_valid = 1'b1; tick(1); dist_valid = 1'b0;
        check("stale_fresh_on", 32'(relay_out), 1);
        k = 0;
        while (state != 2'd3 && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("stale_fault_delay", k, STALE + 1);
        check("stale_fault", 32'(fault), 1);
        req_auto = 1'b0; tick(1);
        fault_clr = 1'b1; tick(1); fault_clr = 1'b0;
        tick(11);
        req_auto = 1'b1; tick(5);
        check("stale_block_relay", 32'(relay_out), 0);
        check("stale_block_idle", 32'(state), 0);
        req_auto = 1'b0; tick(1);
`else
        req_auto = 1'b1; tick(1);
        check("nostale_on", 32'(relay_out), 1);
        tick(29);
        check("nostale_no_fault", 32'(fault), 0);
        req_auto = 1'b0; tick(12);
`endif

        // Mode change and lockout while on.
        mode = 2'd0; req_manual = 1'b1; req_auto = 1'b1; tick(3);
        check("mc_on_src", 32'(active_src), 0);
        mode = 2'd1; tick(1);
        check("mc_relay_off", 32'(relay_out), 0);
        check("mc_cool", 32'(state), 2);
        req_manual = 1'b0; req_auto = 1'b0; mode = 2'd0; tick(12);
        req_manual = 1'b1; tick(3);
        mode = 2'd3; tick(1);
        check("lock_relay_off", 32'(relay_out), 0);
        check("lock_cool", 32'(state), 2);
        req_manual = 1'b0; mode = 2'd0; tick(12);

        // Anti-chatter: one-cycle dropout forces the full off-time.
        req_manual = 1'b1; tick(3);
        req_manual = 1'b0; tick(1);
        check("chat_off", 32'(relay_out), 0);
        req_manual = 1'b1;
        k = 0;
        while (!relay_out && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("chat_restart", k, MIN_OFF + 1);
        tick(20);
        req_manual = 1'b0; tick(1);
        check("chat_last_ms", 32'(last_on_ms), 5);
        tick(12);

        // Reset in the middle of a session.
        req_manual = 1'b1; tick(5);
        check("rstmid_on", 32'(relay_out), 1);
        rst_n = 1'b0; tick(1);
        check("rstmid_relay", 32'(relay_out), 0);
        check("rstmid_state", 32'(state), 0);
        check("rstmid_last", 32'(last_on_ms), 0);
        rst_n = 1'b1; req_manual = 1'b0; tick(3);

        // Randomized traffic; the compare process checks every cycle.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if ($urandom_range(31) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(11) == 0) req_manual = ~req_manual;
            if ($urandom_range(11) == 0) req_auto = ~req_auto;
            if ($urandom_range(11) == 0) req_remote = ~req_remote;
            dist_valid = ((cyc % 256) < 190) && ($urandom_range(7) == 0);
            fault_clr = ($urandom_range(5) == 0);
            rst_n = ($urandom_range(399) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
